// File: rtl/port_arbiter3_if.sv
// ============================================================================
// Module      : port_arbiter3_if
// Description : Request/grant bundle between three requesters and the
//               port_arbiter3 round-robin arbiter of a shared 32-bit port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface port_arbiter3_if;
    logic [2:0] req;
    logic [2:0] last;
    logic       port_ready;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    // Requester / port side
    modport master (
        output req,
        output last,
        output port_ready,
        input  gnt,
        input  sel,
        input  busy,
        input  timeout
    );

    // Arbiter side
    modport slave (
        input  req,
        input  last,
        input  port_ready,
        output gnt,
        output sel,
        output busy,
        output timeout
    );
endinterface

`default_nettype wire

// File: rtl/port_arbiter3.sv
// ============================================================================
// Module      : port_arbiter3
// Description : Three-way round-robin arbiter holding the grant for a whole
//               multi-beat transaction and driving the mux3_1 select.
//               Optional hold-time watchdog: define PORT_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module port_arbiter3 #(
    parameter int MAX_HOLD = 16
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    port_arbiter3_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [1:0] r_own;
    logic [2:0] r_gnt;

    logic       w_own_req;
    logic       w_own_last;
    logic       w_rel_norm;
    logic       w_force;
    logic       w_release;
    logic [2:0] w_arb_req;
    logic       w_win_vld;
    logic [1:0] w_win;
    logic       w_take;

    function automatic logic f_bit(input logic [2:0] r, input logic [1:0] idx);
        case (idx)
            2'd0:    f_bit = r[0];
            2'd1:    f_bit = r[1];
            default: f_bit = r[2];
        endcase
    endfunction

    // Returns {valid, index} of the first set bit scanning p, p+1, p+2 (mod 3)
    function automatic logic [2:0] f_pick(input logic [2:0] r, input logic [1:0] p);
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] c;
        case (p)
            2'd1:    begin a = 2'd1; b = 2'd2; c = 2'd0; end
            2'd2:    begin a = 2'd2; b = 2'd0; c = 2'd1; end
            default: begin a = 2'd0; b = 2'd1; c = 2'd2; end
        endcase
        if (f_bit(r, a))      f_pick = {1'b1, a};
        else if (f_bit(r, b)) f_pick = {1'b1, b};
        else if (f_bit(r, c)) f_pick = {1'b1, c};
        else                  f_pick = 3'b000;
    endfunction

    function automatic logic [1:0] f_inc(input logic [1:0] idx);
        f_inc = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [2:0] f_onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    f_onehot = 3'b001;
            2'd1:    f_onehot = 3'b010;
            default: f_onehot = 3'b100;
        endcase
    endfunction

`ifdef PORT_ARB_TIMEOUT_EN
    localparam int                c_hold_w   = $clog2(MAX_HOLD) + 1;
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(MAX_HOLD - 1);

    logic [c_hold_w-1:0] r_hold;
    logic                r_timeout;

    // Watchdog only fires when the owner is not releasing on its own
    assign w_force = (r_state == ST_GRANT) && !w_rel_norm && (r_hold == c_hold_max);
    assign bus.timeout = r_timeout;
`else
    logic w_unused_max_hold;

    assign w_unused_max_hold = (MAX_HOLD < 2);
    assign w_force           = 1'b0;
    assign bus.timeout       = 1'b0;
`endif

    // r_gnt is the one-hot of the owner while granted and zero while idle
    assign w_own_req  = |(bus.req & r_gnt);
    assign w_own_last = |(bus.last & r_gnt);
    assign w_rel_norm = (r_state == ST_GRANT) &&
                        (!w_own_req || (bus.port_ready && w_own_last));
    assign w_release  = w_rel_norm || w_force;

    assign w_arb_req            = bus.req & ~r_gnt;
    assign {w_win_vld, w_win}   = f_pick(w_arb_req, r_ptr);
    assign w_take               = w_win_vld && ((r_state == ST_IDLE) || w_release);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 2'd0;
            r_own     <= 2'd0;
            r_gnt     <= 3'b000;
`ifdef PORT_ARB_TIMEOUT_EN
            r_hold    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef PORT_ARB_TIMEOUT_EN
            r_timeout <= w_force;
`endif
            if (w_take) begin
                r_state <= ST_GRANT;
                r_gnt   <= f_onehot(w_win);
                r_own   <= w_win;
                r_ptr   <= f_inc(w_win);
`ifdef PORT_ARB_TIMEOUT_EN
                r_hold  <= '0;
`endif
            end else if (w_release) begin
                // sel keeps the previous owner while idle
                r_state <= ST_IDLE;
                r_gnt   <= 3'b000;
            end
`ifdef PORT_ARB_TIMEOUT_EN
            else if (r_state == ST_GRANT) begin
                r_hold  <= r_hold + 1'b1;
            end
`endif
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.sel  = r_own;
    assign bus.busy = |r_gnt;

endmodule

`default_nettype wire

// File: tb/tb_port_arbiter3.sv
// ============================================================================
// Module      : tb_port_arbiter3
// Description : Directed self-checking bench for port_arbiter3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_port_arbiter3;

`ifdef PORT_ARB_TIMEOUT_EN
    localparam int c_max_hold = 4;
`else
    localparam int c_max_hold = 16;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    port_arbiter3_if bus();

    port_arbiter3 #(.MAX_HOLD(c_max_hold)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req        = 3'b000;
        bus.last       = 3'b000;
        bus.port_ready = 1'b0;
        rst_n          = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.req        = 3'b111;
        bus.last       = 3'b000;
        bus.port_ready = 1'b0;
        step();
        step();
        total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt got %b want 000", bus.gnt); end
        total++; if (bus.sel !== 2'b00) begin bad++; $display("FAIL reset_sel got %b want 00", bus.sel); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got %b want 0", bus.timeout); end
        rst_n = 1'b1;
        step();
        total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL first_gnt got %b want 001", bus.gnt); end
        total++; if (bus.sel !== 2'b00) begin bad++; $display("FAIL first_sel got %b want 00", bus.sel); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL first_busy got %b want 1", bus.busy); end
        step();
        // asynchronous assertion mid-transaction, between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL async_rst_gnt got %b want 000", bus.gnt); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL async_rst_busy got %b want 0", bus.busy); end
        bus.req = 3'b000;
        step();
    endtask

    task automatic test_burst();
        do_reset();
        bus.req        = 3'b010;
        bus.port_ready = 1'b1;
        bus.last       = 3'b101;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL burst_gnt beat%0d got %b want 010", i, bus.gnt); end
            total++; if (bus.sel !== 2'b01) begin bad++; $display("FAIL burst_sel beat%0d got %b want 01", i, bus.sel); end
            if (i == 3) bus.last = 3'b111;
        end
        step();
        bus.req  = 3'b000;
        bus.last = 3'b000;
        total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL burst_end_gnt got %b want 000", bus.gnt); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL burst_end_busy got %b want 0", bus.busy); end
        total++; if (bus.sel !== 2'b01) begin bad++; $display("FAIL burst_idle_sel got %b want 01", bus.sel); end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL burst_timeout got %b want 0", bus.timeout); end
        step();
    endtask

    task automatic test_fairness();
        logic [2:0] exp_gnt [5];
        logic [1:0] exp_sel [5];
        exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        exp_sel = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
        do_reset();
        bus.req        = 3'b111;
        bus.last       = 3'b111;
        bus.port_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (bus.gnt !== exp_gnt[i]) begin bad++; $display("FAIL fair_gnt step%0d got %b want %b", i, bus.gnt, exp_gnt[i]); end
            total++; if (bus.sel !== exp_sel[i]) begin bad++; $display("FAIL fair_sel step%0d got %b want %b", i, bus.sel, exp_sel[i]); end
        end
        bus.req = 3'b000;
        step();
        total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL fair_end_gnt got %b want 000", bus.gnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.req        = 3'b001;
        bus.last       = 3'b001;
        bus.port_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL bp_gnt cyc%0d got %b want 001", i, bus.gnt); end
            if (i == 3) bus.port_ready = 1'b1;
        end
        step();
        bus.req = 3'b000;
        total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL bp_release_gnt got %b want 000", bus.gnt); end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL bp_timeout got %b want 0", bus.timeout); end
        step();
    endtask

    task automatic test_abort();
        do_reset();
        bus.req        = 3'b100;
        bus.last       = 3'b000;
        bus.port_ready = 1'b1;
        step();
        bus.req = 3'b101;
        step();
        total++; if (bus.gnt !== 3'b100) begin bad++; $display("FAIL abort_own2_gnt got %b want 100", bus.gnt); end
        total++; if (bus.sel !== 2'b10) begin bad++; $display("FAIL abort_own2_sel got %b want 10", bus.sel); end
        bus.req = 3'b001;
        step();
        total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL abort_handoff_gnt got %b want 001", bus.gnt); end
        total++; if (bus.sel !== 2'b00) begin bad++; $display("FAIL abort_handoff_sel got %b want 00", bus.sel); end
        bus.req = 3'b000;
        step();
        total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL abort_idle_gnt got %b want 000", bus.gnt); end
        // pointer now 1: requesters 0 and 1 together must yield 1
        bus.req = 3'b011;
        step();
        total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL abort_ptr_gnt got %b want 010", bus.gnt); end
        total++; if (bus.sel !== 2'b01) begin bad++; $display("FAIL abort_ptr_sel got %b want 01", bus.sel); end
        bus.req = 3'b000;
        step();
    endtask

`ifdef PORT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        bus.req        = 3'b010;
        bus.last       = 3'b000;
        bus.port_ready = 1'b1;
        step();
        bus.req = 3'b110;
        total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL to_gnt cyc0 got %b want 010", bus.gnt); end
        for (int i = 1; i < 4; i++) begin
            step();
            total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL to_gnt cyc%0d got %b want 010", i, bus.gnt); end
            total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL to_early_pulse cyc%0d got %b want 0", i, bus.timeout); end
        end
        step();
        total++; if (bus.gnt !== 3'b100) begin bad++; $display("FAIL to_forced_gnt got %b want 100", bus.gnt); end
        total++; if (bus.timeout !== 1'b1) begin bad++; $display("FAIL to_pulse got %b want 1", bus.timeout); end
        bus.req = 3'b100;
        step();
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL to_pulse_width got %b want 0", bus.timeout); end
        total++; if (bus.gnt !== 3'b100) begin bad++; $display("FAIL to_new_owner got %b want 100", bus.gnt); end
        bus.req = 3'b000;
        step();
    endtask
`endif

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        bus.req        = 3'b000;
        bus.last       = 3'b000;
        bus.port_ready = 1'b0;
        test_reset();
        test_burst();
        test_fairness();
        test_backpressure();
        test_abort();
`ifdef PORT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
